// File: rtl/glitch_pkg.sv
// Shared definitions for the glitch-generation slice.
//   - Default field widths, shared with the UART command handler.
//   - FSM state encoding for pulse_generator.
//   - max3(): sizes a counter that must hold any of three fields.
package glitch_pkg;

   localparam int DELAY_W_DEF   = 16;
   localparam int WIDTH_W_DEF   = 8;
   localparam int COUNT_W_DEF   = 8;
   localparam int SPACING_W_DEF = 16;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARMED = 3'd1,
      ST_DELAY = 3'd2,
      ST_PULSE = 3'd3,
      ST_GAP   = 3'd4
   } state_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer followed by a rising-edge detector.
//   clk, rst : system clock, synchronous active-high reset
//   d_i      : asynchronous input
//   q_o      : synchronized level (last synchronizer stage)
//   rise_o   : one-cycle pulse when q_o goes 0 -> 1 (combinational from flops)
module sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o,
   output logic rise_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   dly_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         dly_q  <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
         dly_q  <= sync_q[SYNC_STAGES-1];
      end
   end

   assign q_o    = sync_q[SYNC_STAGES-1];
   assign rise_o = sync_q[SYNC_STAGES-1] & ~dly_q;

endmodule

// File: rtl/pulse_generator.sv
// Glitch pulse-train generator.
//   clk, rst         : system clock, synchronous active-high reset
//   trigger_i        : asynchronous target trigger, rising edge starts a train
//   delay_i          : cycles from trigger detection to first pulse
//   width_i          : high cycles per pulse
//   num_pulses_i     : pulses per train
//   pulse_spacing_i  : low cycles between pulses (0 treated as 1)
//   pulse_en_i       : arm level; rising edge arms, low aborts
//   pulse_o          : registered glitch output
//   armed_o, busy_o  : registered status (ARMED / DELAY|PULSE|GAP)
//   done_o           : one-cycle strobe on normal completion
module pulse_generator
   import glitch_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int DELAY_W     = DELAY_W_DEF,
   parameter int WIDTH_W     = WIDTH_W_DEF,
   parameter int COUNT_W     = COUNT_W_DEF,
   parameter int SPACING_W   = SPACING_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 trigger_i,
   input  logic [DELAY_W-1:0]   delay_i,
   input  logic [WIDTH_W-1:0]   width_i,
   input  logic [COUNT_W-1:0]   num_pulses_i,
   input  logic [SPACING_W-1:0] pulse_spacing_i,
   input  logic                 pulse_en_i,
   output logic                 pulse_o,
   output logic                 armed_o,
   output logic                 busy_o,
   output logic                 done_o
);

   // One down-counter serves delay, width and spacing phases.
   localparam int CNT_W = max3(DELAY_W, WIDTH_W, SPACING_W);

   state_t               state, state_nx;
   logic [CNT_W-1:0]     cnt, cnt_nx;
   logic [WIDTH_W-1:0]   width_q, width_nx;
   logic [COUNT_W-1:0]   num_q, num_nx;
   logic [SPACING_W-1:0] space_q, space_nx;
   logic [COUNT_W-1:0]   pdone, pdone_nx;
   logic                 pulse_nx, done_nx;
   logic                 en_q;
   logic                 en_rise;
   logic                 trig_rise;
   logic                 trig_sync_unused;
   logic [CNT_W-1:0]     width_m1, gap_m1;

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk    (clk),
      .rst    (rst),
      .d_i    (trigger_i),
      .q_o    (trig_sync_unused),
      .rise_o (trig_rise)
   );

   assign en_rise  = pulse_en_i & ~en_q;
   assign width_m1 = CNT_W'(width_q) - CNT_W'(1);
   // Spacing of 0 is clamped to 1 so back-to-back pulses never merge.
   assign gap_m1   = (space_q == '0) ? '0 : CNT_W'(space_q) - CNT_W'(1);

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      width_nx = width_q;
      num_nx   = num_q;
      space_nx = space_q;
      pdone_nx = pdone;
      pulse_nx = 1'b0;
      done_nx  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (en_rise) state_nx = ST_ARMED;
         end
         ST_ARMED: begin
            // Abort takes priority over a coincident trigger.
            if (!pulse_en_i) begin
               state_nx = ST_IDLE;
            end else if (trig_rise) begin
               width_nx = width_i;
               num_nx   = num_pulses_i;
               space_nx = pulse_spacing_i;
               pdone_nx = '0;
               if (num_pulses_i == '0 || width_i == '0) begin
                  state_nx = ST_IDLE;
                  done_nx  = 1'b1;
               end else begin
                  cnt_nx   = CNT_W'(delay_i);
                  state_nx = ST_DELAY;
               end
            end
         end
         ST_DELAY: begin
            if (!pulse_en_i) begin
               state_nx = ST_IDLE;
            end else if (cnt == '0) begin
               cnt_nx   = width_m1;
               pulse_nx = 1'b1;
               state_nx = ST_PULSE;
            end else begin
               cnt_nx = cnt - CNT_W'(1);
            end
         end
         ST_PULSE: begin
            pulse_nx = 1'b1;
            if (!pulse_en_i) begin
               pulse_nx = 1'b0;
               state_nx = ST_IDLE;
            end else if (cnt == '0) begin
               pulse_nx = 1'b0;
               if (pdone == num_q - COUNT_W'(1)) begin
                  done_nx  = 1'b1;
                  state_nx = ST_IDLE;
               end else begin
                  cnt_nx   = gap_m1;
                  state_nx = ST_GAP;
               end
            end else begin
               cnt_nx = cnt - CNT_W'(1);
            end
         end
         ST_GAP: begin
            if (!pulse_en_i) begin
               state_nx = ST_IDLE;
            end else if (cnt == '0) begin
               pulse_nx = 1'b1;
               cnt_nx   = width_m1;
               pdone_nx = pdone + COUNT_W'(1);
               state_nx = ST_PULSE;
            end else begin
               cnt_nx = cnt - CNT_W'(1);
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         width_q <= '0;
         num_q   <= '0;
         space_q <= '0;
         pdone   <= '0;
         en_q    <= 1'b0;
         pulse_o <= 1'b0;
         done_o  <= 1'b0;
         armed_o <= 1'b0;
         busy_o  <= 1'b0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         width_q <= width_nx;
         num_q   <= num_nx;
         space_q <= space_nx;
         pdone   <= pdone_nx;
         en_q    <= pulse_en_i;
         pulse_o <= pulse_nx;
         done_o  <= done_nx;
         // Status flags track the state being entered, so they line up with it.
         armed_o <= (state_nx == ST_ARMED);
         busy_o  <= (state_nx == ST_DELAY) || (state_nx == ST_PULSE) ||
                    (state_nx == ST_GAP);
      end
   end

endmodule

// File: tb/tb_pulse_generator.sv
module tb_pulse_generator;

   logic        clk = 1'b0;
   logic        rst;
   logic        trigger_i;
   logic [15:0] delay_i;
   logic [7:0]  width_i;
   logic [7:0]  num_pulses_i;
   logic [15:0] pulse_spacing_i;
   logic        pulse_en_i;
   logic        pulse_o, armed_o, busy_o, done_o;

   int errors = 0;
   int checks = 0;

   pulse_generator dut (
      .clk             (clk),
      .rst             (rst),
      .trigger_i       (trigger_i),
      .delay_i         (delay_i),
      .width_i         (width_i),
      .num_pulses_i    (num_pulses_i),
      .pulse_spacing_i (pulse_spacing_i),
      .pulse_en_i      (pulse_en_i),
      .pulse_o         (pulse_o),
      .armed_o         (armed_o),
      .busy_o          (busy_o),
      .done_o          (done_o)
   );

   always #5 clk = ~clk;

   // Expected {pulse, done, busy, armed} i edges after the edge that first
   // samples the trigger high. Derived from the timing rules: detection takes
   // 2 sync stages, first pulse rises at 3+delay, pulses repeat every
   // width+max(spacing,1) cycles.
   function automatic logic [3:0] model(input int i, input int d, input int w,
                                        input int n, input int s);
      int sp, first, per, dn;
      logic p, dd, b, a;
      sp = (s == 0) ? 1 : s;
      first = 3 + d;
      per = w + sp;
      a = (i < 2);
      p = 1'b0;
      if (n == 0 || w == 0) begin
         dd = (i == 2);
         b  = 1'b0;
      end else begin
         dn = first + (n - 1) * per + w;
         dd = (i == dn);
         b  = (i >= 2) && (i < dn);
         if (i >= first && i < dn) p = ((i - first) % per) < w;
      end
      return {p, dd, b, a};
   endfunction

   function automatic int seq_len(input int d, input int w, input int n, input int s);
      int sp;
      sp = (s == 0) ? 1 : s;
      if (n == 0 || w == 0) return 6;
      return 3 + d + (n - 1) * (w + sp) + w + 3;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic arm();
      trigger_i  = 1'b0;
      pulse_en_i = 1'b0;
      repeat (4) tick();
      pulse_en_i = 1'b1;
      tick();
      checks++;
      if (armed_o !== 1'b1) begin
         errors++;
         $display("FAIL arm: armed_o=%b want 1", armed_o);
      end
   endtask

   task automatic set_params(input int d, input int w, input int n, input int s);
      delay_i         = 16'(d);
      width_i         = 8'(w);
      num_pulses_i    = 8'(n);
      pulse_spacing_i = 16'(s);
   endtask

   task automatic test_reset();
      rst = 1'b1; trigger_i = 1'b0; pulse_en_i = 1'b0;
      set_params(0, 0, 0, 0);
      repeat (2) tick();
      checks++;
      if ({pulse_o, done_o, busy_o, armed_o} !== 4'b0000) begin
         errors++;
         $display("FAIL reset: outs=%b want 0000", {pulse_o, done_o, busy_o, armed_o});
      end
      rst = 1'b0;
      // Level-high enable out of reset arms (edge flop resets to 0); a held
      // level afterwards must not re-arm once it is dropped by abort.
      tick();
   endtask

   // basic, train, num=0, width=0, spacing=0 cases
   task automatic test_directed();
      int tbl [5][4] = '{'{10, 4, 1, 0}, '{0, 2, 3, 5}, '{5, 3, 0, 2},
                         '{5, 0, 3, 2}, '{1, 3, 2, 0}};
      logic [3:0] exp, got;
      for (int t = 0; t < 5; t++) begin
         set_params(tbl[t][0], tbl[t][1], tbl[t][2], tbl[t][3]);
         arm();
         trigger_i = 1'b1;
         for (int i = 0; i < seq_len(tbl[t][0], tbl[t][1], tbl[t][2], tbl[t][3]); i++) begin
            tick();
            exp = model(i, tbl[t][0], tbl[t][1], tbl[t][2], tbl[t][3]);
            got = {pulse_o, done_o, busy_o, armed_o};
            checks++;
            if (got !== exp) begin
               errors++;
               $display("FAIL directed%0d cyc%0d: {pulse,done,busy,armed}=%b want %b", t, i, got, exp);
            end
         end
         trigger_i = 1'b0;
      end
   endtask

   // random params; inputs scrambled and trigger toggled after the latch point
   task automatic test_latch_random();
      int d, w, n, s;
      logic [3:0] exp, got;
      for (int t = 0; t < 10; t++) begin
         d = $urandom_range(0, 30); w = $urandom_range(1, 6);
         n = $urandom_range(1, 5);  s = $urandom_range(0, 6);
         // a trigger glitch while IDLE must not arm or fire
         pulse_en_i = 1'b0; trigger_i = 1'b1; tick(); trigger_i = 1'b0;
         repeat (4) tick();
         checks++;
         if ({pulse_o, armed_o, busy_o} !== 3'b000) begin
            errors++;
            $display("FAIL idle_glitch%0d: {pulse,armed,busy}=%b want 000", t, {pulse_o, armed_o, busy_o});
         end
         set_params(d, w, n, s);
         arm();
         trigger_i = 1'b1;
         for (int i = 0; i < seq_len(d, w, n, s); i++) begin
            tick();
            exp = model(i, d, w, n, s);
            got = {pulse_o, done_o, busy_o, armed_o};
            checks++;
            if (got !== exp) begin
               errors++;
               $display("FAIL random%0d (d=%0d w=%0d n=%0d s=%0d) cyc%0d: got %b want %b",
                        t, d, w, n, s, i, got, exp);
            end
            if (i >= 2) begin
               set_params($urandom_range(0, 50), $urandom_range(0, 9),
                          $urandom_range(0, 9), $urandom_range(0, 9));
               if (i >= 3) trigger_i = 1'($urandom_range(0, 1));
            end
         end
         trigger_i = 1'b0;
      end
   endtask

   task automatic test_abort_oneshot();
      logic [3:0] exp, got;
      // drop enable in the 2nd pulse (d=2 w=4 n=3 s=2: pulse 2 at cyc 11..14)
      set_params(2, 4, 3, 2);
      arm();
      trigger_i = 1'b1;
      for (int i = 0; i < 22; i++) begin
         tick();
         exp = (i <= 12) ? model(i, 2, 4, 3, 2) : 4'b0000;
         got = {pulse_o, done_o, busy_o, armed_o};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL abort cyc%0d: got %b want %b", i, got, exp);
         end
         if (i == 12) pulse_en_i = 1'b0;
      end
      trigger_i = 1'b0;
      // trigger and enable falling together: abort wins
      set_params(0, 2, 1, 0);
      arm();
      trigger_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         exp = (i < 2) ? 4'b0001 : 4'b0000;
         got = {pulse_o, done_o, busy_o, armed_o};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL abort_vs_trig cyc%0d: got %b want %b", i, got, exp);
         end
         if (i == 1) pulse_en_i = 1'b0;
      end
      trigger_i = 1'b0;
      // complete a train, keep enable high, trigger again: no re-fire
      set_params(1, 1, 1, 0);
      arm();
      trigger_i = 1'b1;
      repeat (seq_len(1, 1, 1, 0)) tick();
      trigger_i = 1'b0;
      repeat (4) tick();
      trigger_i = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         got = {pulse_o, done_o, busy_o, armed_o};
         checks++;
         if (got !== 4'b0000) begin
            errors++;
            $display("FAIL oneshot cyc%0d: got %b want 0000", i, got);
         end
      end
      trigger_i = 1'b0;
      // re-arm with a fresh enable edge: fires again
      set_params(3, 2, 2, 1);
      arm();
      trigger_i = 1'b1;
      for (int i = 0; i < seq_len(3, 2, 2, 1); i++) begin
         tick();
         exp = model(i, 3, 2, 2, 1);
         got = {pulse_o, done_o, busy_o, armed_o};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL rearm cyc%0d: got %b want %b", i, got, exp);
         end
      end
      trigger_i = 1'b0;
   endtask

   // reset during DELAY (d=20) and during PULSE (d=0 w=8, high from cyc 3)
   task automatic test_reset_mid();
      int tbl [2][3] = '{'{20, 5, 2}, '{0, 8, 1}};
      logic [3:0] exp, got;
      for (int t = 0; t < 2; t++) begin
         set_params(tbl[t][0], tbl[t][1], tbl[t][2], 1);
         arm();
         trigger_i = 1'b1;
         for (int i = 0; i < 6; i++) begin
            tick();
            exp = model(i, tbl[t][0], tbl[t][1], tbl[t][2], 1);
            got = {pulse_o, done_o, busy_o, armed_o};
            checks++;
            if (got !== exp) begin
               errors++;
               $display("FAIL pre_rst%0d cyc%0d: got %b want %b", t, i, got, exp);
            end
         end
         rst = 1'b1;
         tick();
         got = {pulse_o, done_o, busy_o, armed_o};
         checks++;
         if (got !== 4'b0000) begin
            errors++;
            $display("FAIL mid_rst%0d: got %b want 0000", t, got);
         end
         pulse_en_i = 1'b0; trigger_i = 1'b0;
         tick();
         rst = 1'b0;
         repeat (3) tick();
         checks++;
         if ({pulse_o, busy_o, armed_o} !== 3'b000) begin
            errors++;
            $display("FAIL post_rst%0d: {pulse,busy,armed}=%b want 000", t, {pulse_o, busy_o, armed_o});
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_latch_random();
      test_abort_oneshot();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
